// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : column-scanned keypad with frame-level debounce and event FIFO
// Revision : 1.0
// ============================================================================
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int CODE_W          = 4,
    parameter int SETTLE          = 4,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   rows,
    output logic [COLS-1:0]   col_drive,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CODE_W:0]   evt_data,
    output logic              key_down,
    output logic [CODE_W-1:0] key_code,
    output logic              overflow,
    input  logic              ovf_clr
);
    localparam int c_COL_W = $clog2(COLS);
    localparam int c_ROW_W = $clog2(ROWS);
    localparam int c_SET_W = $clog2(SETTLE);
    localparam int c_DB_W  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_AW + 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_DEBOUNCE   = 2'd1,
        S_HELD       = 2'd2,
        S_RELEASE_DB = 2'd3
    } state_t;

    logic [c_SET_W-1:0] r_settle;
    logic [c_COL_W-1:0] r_col, r_col_d1, r_col_d2;
    logic [ROWS-1:0]    r_rows_s1, r_rows_s2;
    logic [1:0]         r_smp_pipe;
    logic               w_col_last, w_smp, w_frame_end;

    assign w_col_last  = (r_settle == c_SET_W'(SETTLE - 1));
    assign col_drive   = COLS'(1) << r_col;
    assign w_smp       = r_smp_pipe[1];
    assign w_frame_end = w_smp && (r_col_d2 == c_COL_W'(COLS - 1));

    // Column tag and sample strobe are delayed alongside the synchroniser so a
    // sample always pairs with the rows seen on that column's last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle   <= '0;
            r_col      <= '0;
            r_col_d1   <= '0;
            r_col_d2   <= '0;
            r_rows_s1  <= '0;
            r_rows_s2  <= '0;
            r_smp_pipe <= '0;
        end else begin
            r_rows_s1  <= rows;
            r_rows_s2  <= r_rows_s1;
            r_smp_pipe <= {r_smp_pipe[0], w_col_last};
            r_col_d1   <= r_col;
            r_col_d2   <= r_col_d1;
            if (w_col_last) begin
                r_settle <= '0;
                r_col    <= (r_col == c_COL_W'(COLS - 1)) ? '0 : r_col + 1'b1;
            end else begin
                r_settle <= r_settle + 1'b1;
            end
        end
    end

    logic [1:0]         w_col_hits;
    logic [c_ROW_W-1:0] w_col_row;
    logic               w_col_any;
    logic [CODE_W-1:0]  w_col_code;

    always_comb begin
        w_col_hits = 2'd0;
        w_col_row  = '0;
        w_col_any  = 1'b0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (r_rows_s2[r]) begin
                w_col_row = c_ROW_W'(r);
                w_col_any = 1'b1;
                if (w_col_hits != 2'd2) w_col_hits = w_col_hits + 2'd1;
            end
        end
    end

    assign w_col_code = CODE_W'(w_col_row) * CODE_W'(COLS) + CODE_W'(r_col_d2);

    logic [1:0]         r_acc_cnt, w_frm_cnt;
    logic [c_ROW_W-1:0] r_acc_row, w_frm_row;
    logic [c_COL_W-1:0] r_acc_col, w_frm_col;
    logic               r_acc_hit, w_frm_hit, w_take_col;
    logic [CODE_W-1:0]  w_acc_code, w_frm_code;
    logic [c_ROW_W-1:0] r_cand_row, w_cand_row_nxt;
    logic [c_COL_W-1:0] r_cand_col, w_cand_col_nxt;
    logic [CODE_W-1:0]  w_cand_code;

    assign w_acc_code  = CODE_W'(r_acc_row) * CODE_W'(COLS) + CODE_W'(r_acc_col);
    assign w_cand_code = CODE_W'(r_cand_row) * CODE_W'(COLS) + CODE_W'(r_cand_col);
    assign w_take_col  = w_col_any && ((r_acc_cnt == 2'd0) || (w_col_code < w_acc_code));
    assign w_frm_cnt   = ((r_acc_cnt == 2'd2) || (w_col_hits == 2'd2) ||
                          ((r_acc_cnt == 2'd1) && (w_col_hits == 2'd1))) ? 2'd2
                                                                         : (r_acc_cnt | w_col_hits);
    assign w_frm_row   = w_take_col ? w_col_row : r_acc_row;
    assign w_frm_col   = w_take_col ? r_col_d2 : r_acc_col;
    assign w_frm_code  = w_take_col ? w_col_code : w_acc_code;
    assign w_frm_hit   = r_acc_hit | ((r_col_d2 == r_cand_col) && r_rows_s2[r_cand_row]);

    always_ff @(posedge clk) begin
        if (rst || (w_smp && w_frame_end)) begin
            r_acc_cnt <= '0;
            r_acc_row <= '0;
            r_acc_col <= '0;
            r_acc_hit <= 1'b0;
        end else if (w_smp) begin
            r_acc_cnt <= w_frm_cnt;
            r_acc_row <= w_frm_row;
            r_acc_col <= w_frm_col;
            r_acc_hit <= w_frm_hit;
        end
    end

    state_t             r_state, w_state_nxt;
    logic [c_DB_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic               w_push, w_key_load;
    logic [CODE_W:0]    w_push_data;
    logic [CODE_W-1:0]  r_key_code;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cand_row <= '0;
            r_cand_col <= '0;
            r_key_code <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cand_row <= w_cand_row_nxt;
            r_cand_col <= w_cand_col_nxt;
            if (w_key_load) r_key_code <= w_push_data[CODE_W-1:0];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cand_row_nxt = r_cand_row;
        w_cand_col_nxt = r_cand_col;
        w_push         = 1'b0;
        w_push_data    = '0;
        w_key_load     = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_frm_cnt == 2'd1) begin
                        w_cand_row_nxt = w_frm_row;
                        w_cand_col_nxt = w_frm_col;
                        w_cnt_nxt      = c_DB_W'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_push      = 1'b1;
                            w_push_data = {1'b0, w_frm_code};
                            w_key_load  = 1'b1;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_state_nxt = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if ((w_frm_cnt == 2'd1) && (w_frm_code == w_cand_code)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_DB_W'(DEBOUNCE_FRAMES)) begin
                            w_push      = 1'b1;
                            w_push_data = {1'b0, w_cand_code};
                            w_key_load  = 1'b1;
                            w_state_nxt = S_HELD;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (!w_frm_hit) begin
                        w_cnt_nxt = c_DB_W'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_push      = 1'b1;
                            w_push_data = {1'b1, w_cand_code};
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_RELEASE_DB;
                        end
                    end
                end
                S_RELEASE_DB: begin
                    if (!w_frm_hit) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_DB_W'(DEBOUNCE_FRAMES)) begin
                            w_push      = 1'b1;
                            w_push_data = {1'b1, w_cand_code};
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_state_nxt = S_HELD;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign key_down = (r_state == S_HELD) || (r_state == S_RELEASE_DB);
    assign key_code = r_key_code;

    logic [CODE_W:0]    r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr, r_rd;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full, w_pop, w_wr_en, w_drop, r_ovf;

    assign w_full    = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign evt_valid = (r_count != '0);
    assign w_pop     = evt_valid && evt_ready;
    assign w_wr_en   = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;
    assign evt_data  = evt_valid ? r_mem[r_rd] : '0;
    assign overflow  = r_ovf;

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr] <= w_push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_pop)   r_rd <= r_rd + 1'b1;
            if (w_wr_en && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr_en && w_pop) r_count <= r_count - 1'b1;
            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

endmodule
`default_nettype wire
